replica_distance: RTL and testbench

Downstream consumer of a replica's route RAM stream in the replica-exchange salesman engine. On each non-NOP command it takes the `city_num` city indices streamed out of the RAM and looks up every consecutive edge, including the closing edge, in a loadable distance table. It accumulates the total tour length and reports it with a one-cycle valid strobe to the exchange/Metropolis decision logic.

---
 rtl/replica_pkg.sv | 43 ++++
 rtl/distance_table.sv | 51 +++++
 rtl/replica_distance.sv | 208 ++++++++++++++++++++
 tb/tb_replica_distance.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/replica_pkg.sv
// replica_pkg: shared types for the replica route RAM, its command bus and the
// tour-length evaluator (replica_distance). city_num is the tour size and must
// be at least 2.
package replica_pkg;

    localparam int city_num = 4;
    localparam int city_w   = $clog2(city_num);
    localparam int dist_w   = 16;
    localparam int total_w  = dist_w + $clog2(city_num);

    // City index as streamed by the route RAM.
    typedef logic [city_w-1:0] replica_data;

    // Sum of city_num edges of dist_w bits each; cannot overflow.
    typedef logic [total_w-1:0] total_data;

    // Command bus shared with the route RAM; anything but NOP starts an evaluation.
    typedef enum logic [1:0] {
        NOP       = 2'd0,
        CMD_READ  = 2'd1,
        CMD_WRITE = 2'd2,
        CMD_SWAP  = 2'd3
    } replica_command;

    // Evaluator FSM states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_RUN   = 3'd2,
        ST_CLOSE = 3'd3,
        ST_DRAIN = 3'd4
    } dist_state_e;

    localparam replica_data last_idx = replica_data'(city_num - 1);

    // Flat index into the city_num x city_num distance table.
    typedef logic [$clog2(city_num * city_num)-1:0] cell_idx_t;

    function automatic cell_idx_t cell_index(input replica_data row, input replica_data col);
        return cell_idx_t'(cell_idx_t'(row) * cell_idx_t'(city_num) + cell_idx_t'(col));
    endfunction

endpackage

// File: rtl/distance_table.sv
// distance_table: city_num x city_num simple dual-port RAM. Synchronous write
// port, registered read port with one cycle of latency. A read and a write of
// the same cell in one cycle return the old contents. Contents are never reset.
module distance_table
    import replica_pkg::*;
#(
    parameter int DIST_W = dist_w
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  replica_data       wa,
    input  replica_data       wb,
    input  logic [DIST_W-1:0] wdata,
    input  replica_data       ra,
    input  replica_data       rb,
    output logic [DIST_W-1:0] rdata
);

    logic [DIST_W-1:0] mem_q [city_num * city_num];
    logic [DIST_W-1:0] rd_data_q;
    logic [DIST_W-1:0] rd_data_d;
    cell_idx_t         wr_idx_s;
    cell_idx_t         rd_idx_s;

    // Address decode and read-data selection.
    always_comb begin
        wr_idx_s  = cell_index(wa, wb);
        rd_idx_s  = cell_index(ra, rb);
        rd_data_d = mem_q[rd_idx_s];
    end

    // Table storage; contents survive reset so the host loads it only once.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_idx_s] <= wdata;
        end
    end

    // Registered read port; samples pre-write contents on a same-cell collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rdata = rd_data_q;

endmodule

// File: rtl/replica_distance.sv
// replica_distance: computes the closed tour length of the route streamed out of
// a replica's route RAM, using a host-loaded distance table. Reports the result
// with a one-cycle dist_valid strobe.
// Optional feature macro: REPLICA_DIST_BEST_EN adds a running-minimum `best`
// output updated alongside `total`.
module replica_distance
    import replica_pkg::*;
#(
    parameter int DIST_W = dist_w
) (
    input  logic              clk,
    input  logic              reset,
    input  replica_command    command,
    input  replica_data       in_data,
    input  logic              dist_we,
    input  replica_data       dist_wa,
    input  replica_data       dist_wb,
    input  logic [DIST_W-1:0] dist_wdata,
    output logic              busy,
    output logic              dist_valid,
    output total_data         total
`ifdef REPLICA_DIST_BEST_EN
    ,
    output total_data         best
`endif
);

    dist_state_e       state_q, state_d;
    replica_data       k_q, k_d;
    logic              drain_q, drain_d;
    replica_data       first_q, first_d;
    replica_data       prev_q, prev_d;
    logic              rd_pend_q, rd_pend_d;
    total_data         acc_q, acc_d;
    logic              busy_q, busy_d;
    logic              dist_valid_q, dist_valid_d;
    total_data         total_q, total_d;

    logic              rd_issue_s;
    replica_data       rd_col_s;
    logic [DIST_W-1:0] rd_data_s;

    distance_table #(
        .DIST_W (DIST_W)
    ) u_table (
        .clk   (clk),
        .reset (reset),
        .we    (dist_we),
        .wa    (dist_wa),
        .wb    (dist_wb),
        .wdata (dist_wdata),
        .ra    (prev_q),
        .rb    (rd_col_s),
        .rdata (rd_data_s)
    );

    // FSM and datapath state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            k_q          <= '0;
            drain_q      <= 1'b0;
            first_q      <= '0;
            prev_q       <= '0;
            rd_pend_q    <= 1'b0;
            acc_q        <= '0;
            busy_q       <= 1'b0;
            dist_valid_q <= 1'b0;
            total_q      <= '0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            drain_q      <= drain_d;
            first_q      <= first_d;
            prev_q       <= prev_d;
            rd_pend_q    <= rd_pend_d;
            acc_q        <= acc_d;
            busy_q       <= busy_d;
            dist_valid_q <= dist_valid_d;
            total_q      <= total_d;
        end
    end

    // Next-state logic. WAIT spans the single cycle between the accepted
    // command and route element 0 arriving; DRAIN covers the last read's latency
    // plus the cycle in which the result is presented.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (command != NOP) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: state_d = ST_RUN;
            ST_RUN: begin
                if (k_q == last_idx) begin
                    state_d = ST_CLOSE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_CLOSE: state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (drain_q == 1'b1) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: route capture, table read issue, accumulation and result outputs.
    always_comb begin
        k_d          = k_q;
        drain_d      = drain_q;
        first_d      = first_q;
        prev_d       = prev_q;
        rd_issue_s   = 1'b0;
        rd_col_s     = first_q;
        dist_valid_d = 1'b0;
        total_d      = total_q;
        busy_d       = (state_d != ST_IDLE);
        // A read issued last cycle has its data on the RAM output now.
        if (rd_pend_q) begin
            acc_d = acc_q + total_data'(rd_data_s);
        end else begin
            acc_d = acc_q;
        end

        case (state_q)
            ST_IDLE: begin
                k_d     = '0;
                drain_d = 1'b0;
                if (command != NOP) begin
                    acc_d = '0;
                end else begin
                    acc_d = acc_q;
                end
            end
            ST_WAIT: begin
                k_d = '0;
            end
            ST_RUN: begin
                k_d    = k_q + replica_data'(1);
                prev_d = in_data;
                if (k_q == '0) begin
                    first_d = in_data;
                end else begin
                    rd_issue_s = 1'b1;
                    rd_col_s   = in_data;
                end
            end
            ST_CLOSE: begin
                // Closing edge: last city back to the first.
                rd_issue_s = 1'b1;
                rd_col_s   = first_q;
            end
            ST_DRAIN: begin
                drain_d = drain_q + 1'b1;
                if (drain_q == 1'b0) begin
                    dist_valid_d = 1'b1;
                    total_d      = acc_d;
                end else begin
                    dist_valid_d = 1'b0;
                end
            end
            default: begin
                k_d = '0;
            end
        endcase

        rd_pend_d = rd_issue_s;
    end

    assign busy       = busy_q;
    assign dist_valid = dist_valid_q;
    assign total      = total_q;

`ifdef REPLICA_DIST_BEST_EN
    total_data best_q, best_d;

    // Running minimum of completed tour lengths, updated with `total`.
    always_comb begin
        if (dist_valid_d && (total_d < best_q)) begin
            best_d = total_d;
        end else begin
            best_d = best_q;
        end
    end

    // Best-so-far register; reset to all-ones so the first result always wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            best_q <= '1;
        end else begin
            best_q <= best_d;
        end
    end

    assign best = best_q;
`endif

endmodule

// File: tb/tb_replica_distance.sv
// Self-checking bench for replica_distance: table-driven tours, hand-written
// corner sequences (ignored command, write collision, mid-run reset, best
// tracking) and randomized tables/routes against a tour-length model.
module tb_replica_distance;
    import replica_pkg::*;

    localparam int N = city_num;

    typedef int route_t [N];
    typedef struct {
        route_t r;
        int     exp_total;
    } vec_t;

    logic              clk;
    logic              reset;
    replica_command    command;
    replica_data       in_data;
    logic              dist_we;
    replica_data       dist_wa;
    replica_data       dist_wb;
    logic [dist_w-1:0] dist_wdata;
    logic              busy;
    logic              dist_valid;
    total_data         total;
`ifdef REPLICA_DIST_BEST_EN
    total_data         best;
`endif

    int tbl [N][N];
    int errors;
    int checks;
    logic [31:0] exp_best;
    logic [31:0] ones_v;

    replica_distance #(.DIST_W(dist_w)) dut (
        .clk        (clk),
        .reset      (reset),
        .command    (command),
        .in_data    (in_data),
        .dist_we    (dist_we),
        .dist_wa    (dist_wa),
        .dist_wb    (dist_wb),
        .dist_wdata (dist_wdata),
        .busy       (busy),
        .dist_valid (dist_valid),
        .total      (total)
`ifdef REPLICA_DIST_BEST_EN
        ,
        .best       (best)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: sum of d[r[i]][r[i+1]] around the closed tour.
    function automatic int tour_len(input route_t r);
        int s;
        s = 0;
        for (int i = 0; i < N; i++) begin
            s += tbl[r[i]][r[(i + 1) % N]];
        end
        return s;
    endfunction

    task automatic write_cell(input int a, input int b, input int v);
        @(posedge clk); #1;
        dist_we    = 1'b1;
        dist_wa    = replica_data'(a);
        dist_wb    = replica_data'(b);
        dist_wdata = dist_w'(v);
        @(posedge clk); #1;
        dist_we    = 1'b0;
        tbl[a][b]  = v;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_valid"}, 32'(dist_valid), 32'd0);
        check({tag, "_total"}, 32'(total), 32'd0);
`ifdef REPLICA_DIST_BEST_EN
        check({tag, "_best"}, 32'(best), ones_v);
`endif
    endtask

    task automatic pulse_reset(input string tag);
        @(posedge clk); #1;
        reset   = 1'b1;
        command = NOP;
        @(posedge clk); #1;
        reset   = 1'b0;
        @(negedge clk);
        check_reset_outputs(tag);
        exp_best = ones_v;
    endtask

    // One evaluation, command in cycle m=0; optional extra command and table write.
    task automatic run_tour(input route_t r, input int exp_total, input int extra_at,
                            input int wr_at, input int wa, input int wb, input int wv,
                            input string name);
        for (int m = 0; m <= N + 5; m++) begin
            @(posedge clk); #1;
            command = (m == 0 || m == extra_at) ? CMD_READ : NOP;
            if (m >= 2 && m < 2 + N) begin
                in_data = replica_data'(r[m - 2]);
            end else begin
                in_data = replica_data'($urandom);
            end
            if (m == wr_at) begin
                dist_we    = 1'b1;
                dist_wa    = replica_data'(wa);
                dist_wb    = replica_data'(wb);
                dist_wdata = dist_w'(wv);
            end else begin
                dist_we = 1'b0;
            end
            @(negedge clk);
            check({name, "_busy"}, 32'(busy), 32'(m >= 1 && m <= N + 4));
            check({name, "_valid"}, 32'(dist_valid), 32'(m == N + 4));
            if (m == N + 4) begin
                check({name, "_total"}, 32'(total), 32'(exp_total));
`ifdef REPLICA_DIST_BEST_EN
                if (32'(exp_total) < exp_best) exp_best = 32'(exp_total);
                check({name, "_best"}, 32'(best), exp_best);
`endif
            end
        end
        command = NOP;
    endtask

    vec_t   vecs [6];
    route_t rt;

    initial begin
        total_data ones_t;
        errors     = 0;
        checks     = 0;
        ones_t     = '1;
        ones_v     = 32'(ones_t);
        exp_best   = ones_v;
        reset      = 1'b1;
        command    = NOP;
        in_data    = '0;
        dist_we    = 1'b0;
        dist_wa    = '0;
        dist_wb    = '0;
        dist_wdata = '0;

        // Expected totals for d[i][j] = 10*i + j, worked by hand.
        vecs[0].r = '{0, 1, 2, 3}; vecs[0].exp_total = 66;   // 1+12+23+30
        vecs[1].r = '{2, 0, 3, 1}; vecs[1].exp_total = 66;   // 20+3+31+12
        vecs[2].r = '{2, 0, 3, 1}; vecs[2].exp_total = 66;   // repeat run
        vecs[3].r = '{3, 2, 1, 0}; vecs[3].exp_total = 66;   // 32+21+10+3
        vecs[4].r = '{0, 0, 0, 0}; vecs[4].exp_total = 0;    // all d[0][0]
        vecs[5].r = '{3, 3, 3, 3}; vecs[5].exp_total = 132;  // 4*33

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("por");

        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                write_cell(i, j, 10 * i + j);
            end
        end

        for (int v = 0; v < 6; v++) begin
            run_tour(vecs[v].r, vecs[v].exp_total, -1, -1, 0, 0, 0, $sformatf("vec%0d", v));
        end

        // Command during busy is ignored: one strobe, unchanged result.
        rt = '{0, 1, 2, 3};
        run_tour(rt, 66, 3, -1, 0, 0, 0, "ignored_cmd");

        // Write d[1][2] in the cycle its read is issued: old value, then new.
        run_tour(rt, 66, -1, 4, 1, 2, 100, "collide_old");
        tbl[1][2] = 100;
        run_tour(rt, 154, -1, -1, 0, 0, 0, "collide_new");
        write_cell(1, 2, 12);

        // Reset in cycle t0+5 aborts the run with no strobe.
        for (int m = 0; m <= N + 6; m++) begin
            @(posedge clk); #1;
            command = (m == 0) ? CMD_READ : NOP;
            in_data = (m >= 2 && m < 2 + N) ? replica_data'(rt[m - 2]) : replica_data'($urandom);
            reset   = (m == 5);
            @(negedge clk);
            check("abort_valid", 32'(dist_valid), 32'd0);
            if (m == 6) begin
                check_reset_outputs("abort");
                exp_best = ones_v;
            end
        end
        run_tour(rt, 66, -1, -1, 0, 0, 0, "after_abort");

        // Best tracking: totals 66, 50, 80 -> best 66, 50, 50.
        pulse_reset("best_rst");
        run_tour(rt, 66, -1, -1, 0, 0, 0, "best66");
        write_cell(3, 0, 14);
        run_tour(rt, 50, -1, -1, 0, 0, 0, "best50");
        write_cell(3, 0, 44);
        run_tour(rt, 80, -1, -1, 0, 0, 0, "best80");
`ifdef REPLICA_DIST_BEST_EN
        check("best_final", 32'(best), 32'd50);
`endif

        // Randomized tables and routes against the tour-length model.
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    write_cell(i, j, int'($urandom_range(0, 65535)));
                end
            end
            for (int s = 0; s < 3; s++) begin
                for (int i = 0; i < N; i++) rt[i] = int'($urandom_range(0, N - 1));
                run_tour(rt, tour_len(rt), -1, -1, 0, 0, 0, $sformatf("rand%0d_%0d", t, s));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
